// File: rtl/mod_issue_ctrl_pkg.sv
// mod_issue_ctrl shared types: state encoding, data width, default wait.
// Optional build macro: MOD_ISSUE_CTRL_BYPASS_EN (small-dividend bypass).
package mod_issue_ctrl_pkg;

    localparam int DATA_W          = 32;
    localparam int WAIT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // dividend already smaller than a non-zero divisor: remainder is a
    function automatic logic bypass_ok(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (b != '0) && (a < b);
    endfunction

endpackage

// File: rtl/mod_issue_ctrl_if.sv
// Request, datapath and result signals of the MOD issue controller.
// Optional build macro: MOD_ISSUE_CTRL_BYPASS_EN (no effect on this file).
interface mod_issue_ctrl_if
    import mod_issue_ctrl_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              mod_load;
    logic [DATA_W-1:0] mod_a;
    logic [DATA_W-1:0] mod_b;
    logic [DATA_W-1:0] mod_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_divzero;
    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, mod_result, out_ready,
        output in_ready, mod_load, mod_a, mod_b,
        output out_valid, out_result, out_divzero, busy
    );

    modport master (
        output in_valid, in_a, in_b, mod_result, out_ready,
        input  in_ready, mod_load, mod_a, mod_b,
        input  out_valid, out_result, out_divzero, busy
    );

endinterface

// File: rtl/mod_issue_ctrl.sv
// Issue controller for an external fixed-latency MOD datapath.
// Optional build macro: MOD_ISSUE_CTRL_BYPASS_EN (a < b returns a directly).
module mod_issue_ctrl
    import mod_issue_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic            CLK,
    input  logic            reset,
    mod_issue_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              dz_q;
    logic              accept;

    // ready only in IDLE and never while reset is held
    assign bus.in_ready    = reset && (state == S_IDLE);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.mod_load    = (state == S_LOAD);
    assign bus.mod_a       = a_q;
    assign bus.mod_b       = b_q;
    assign bus.out_valid   = (state == S_DONE);
    assign bus.out_result  = res_q;
    assign bus.out_divzero = dz_q;
    assign bus.busy        = (state != S_IDLE);

    // request sequencing: accept, load, count datapath latency, hand off
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q <= bus.in_a;
                        b_q <= bus.in_b;
                        if (bus.in_b == '0) begin
                            state <= S_DONE;
                            res_q <= bus.in_a;
                            dz_q  <= 1'b1;
                        end
`ifdef MOD_ISSUE_CTRL_BYPASS_EN
                        else if (bypass_ok(bus.in_a, bus.in_b)) begin
                            state <= S_DONE;
                            res_q <= bus.in_a;
                            dz_q  <= 1'b0;
                        end
`endif
                        else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        res_q <= bus.mod_result;
                        dz_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
